dram_cmd_gen: RTL

- Sits directly downstream of the request queue and consumes one parsed memory request at a time.
- Decodes each request address into bank group, bank, row and column.
- Tracks the open row of all 16 banks and issues DDR4 PRE/ACT/RD/WR commands with enforced timing.
- Commands are issued in request order, only on DRAM clock edges derived from CPU_clk.

---
 rtl/dram_cmd_gen.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_gen.sv
// In-order DDR4 command sequencer: decodes one request at a time and issues PRE/ACT/RD/WR
// on DRAM edges with per-bank open-row tracking. Define CLOSED_PAGE_EN for auto-precharge.
module dram_cmd_gen #(
    parameter int unsigned ADDRESS_WIDTH = 33,
    parameter int unsigned CLK_RATIO     = 2,
    parameter int unsigned T_RCD         = 24,
    parameter int unsigned T_RP          = 24,
    parameter int unsigned T_RAS         = 52,
    parameter int unsigned T_CAS         = 24,
    parameter int unsigned T_CWL         = 20,
    parameter int unsigned T_BURST       = 4,
    parameter int unsigned TMR_W         = 7
) (
    input  logic                     CPU_clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               opcode_in,   // parsed_op_t: 0=READ, 1=WRITE, 2=IFETCH
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    output logic                     cmd_valid,
    output logic [1:0]               cmd,
    output logic [1:0]               cmd_bg,
    output logic [1:0]               cmd_bank,
    output logic [14:0]              cmd_row,
    output logic [10:0]              cmd_col,
    output logic                     done_s
);

    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] CMD_PRE = 2'd0, CMD_ACT = 2'd1, CMD_RD = 2'd2, CMD_WR = 2'd3;
    localparam int unsigned NUM_BANKS = 16;
    localparam int unsigned PH_W = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;

    if (ADDRESS_WIDTH != 33) begin : g_chk_aw
        $fatal(1, "dram_cmd_gen: ADDRESS_WIDTH must be 33");
    end
    if (CLK_RATIO < 1) begin : g_chk_ratio
        $fatal(1, "dram_cmd_gen: CLK_RATIO must be >= 1");
    end
    if (T_RCD >= (1 << TMR_W) || T_RP >= (1 << TMR_W) || T_RAS >= (1 << TMR_W) ||
        (T_CAS + T_BURST) >= (1 << TMR_W) || (T_CWL + T_BURST) >= (1 << TMR_W)) begin : g_chk_t
        $fatal(1, "dram_cmd_gen: timing parameter does not fit in TMR_W bits");
    end

    // Loads happen on the issuing DRAM edge, which already counts as one elapsed DRAM clock.
    localparam logic [TMR_W-1:0] LD_RCD = TMR_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [TMR_W-1:0] LD_RP  = TMR_W'((T_RP > 0) ? T_RP - 1 : 0);
    localparam logic [TMR_W-1:0] LD_RAS = TMR_W'((T_RAS > 0) ? T_RAS - 1 : 0);
    localparam logic [TMR_W-1:0] LD_RD  = TMR_W'(T_CAS + T_BURST - 1);
    localparam logic [TMR_W-1:0] LD_WR  = TMR_W'(T_CWL + T_BURST - 1);

    typedef enum logic [2:0] {StIdle, StDecode, StPre, StAct, StCol, StData, StDrain} state_e;

    state_e            state_q, state_d;
    logic              req_ready_q;
    logic [PH_W-1:0]   phase_q;
    logic [TMR_W-1:0]  gap_q, data_q;
    logic [TMR_W-1:0]  tras_q [NUM_BANKS];
    logic [14:0]       open_row_q [NUM_BANKS];
    logic [NUM_BANKS-1:0] open_q;
    logic              is_wr_q;
    logic [1:0]        bg_q, bank_q;
    logic [14:0]       row_q;
    logic [10:0]       col_q;

    logic              dram_edge, accept;
    logic [3:0]        bank_idx;
    logic              pre_fire, act_fire, col_fire;
    logic [2:0]        unused_addr_bits;

    assign unused_addr_bits = address_in[2:0];
    assign dram_edge = (phase_q == '0);
    assign accept    = (state_q == StIdle) && req_valid && req_ready_q;
    assign bank_idx  = {bg_q, bank_q};

    assign req_ready = req_ready_q;
    assign cmd_bg    = bg_q;
    assign cmd_bank  = bank_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;

    function automatic logic [TMR_W-1:0] sat_dec(input logic [TMR_W-1:0] t);
        return (t == '0) ? '0 : t - TMR_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        cmd_valid = 1'b0;
        cmd       = CMD_PRE;
        done_s    = 1'b0;
        pre_fire  = 1'b0;
        act_fire  = 1'b0;
        col_fire  = 1'b0;
        unique case (state_q)
            StIdle: if (accept) state_d = StDecode;
            StDecode: begin
                if (!open_q[bank_idx])                 state_d = StAct;
                else if (open_row_q[bank_idx] == row_q) state_d = StCol;
                else                                   state_d = StPre;
            end
            StPre: if (dram_edge && tras_q[bank_idx] == '0) begin
                pre_fire = 1'b1;
                state_d  = StAct;
            end
            StAct: if (dram_edge && gap_q == '0) begin
                act_fire = 1'b1;
                state_d  = StCol;
            end
            StCol: if (dram_edge && gap_q == '0) begin
                col_fire = 1'b1;
                state_d  = StData;
            end
            StData: if (dram_edge && data_q == '0) begin
`ifdef CLOSED_PAGE_EN
                if (tras_q[bank_idx] == '0) begin
                    pre_fire = 1'b1;
                    state_d  = StDrain;
                end
`else
                done_s  = 1'b1;
                state_d = StIdle;
`endif
            end
            StDrain: if (dram_edge && gap_q == '0) begin
                done_s  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (pre_fire) begin
            cmd_valid = 1'b1;
            cmd       = CMD_PRE;
        end else if (act_fire) begin
            cmd_valid = 1'b1;
            cmd       = CMD_ACT;
        end else if (col_fire) begin
            cmd_valid = 1'b1;
            cmd       = is_wr_q ? CMD_WR : CMD_RD;
        end
    end

    always_ff @(posedge CPU_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            phase_q     <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            open_q      <= '0;
            is_wr_q     <= 1'b0;
            bg_q        <= '0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                tras_q[i]     <= '0;
                open_row_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == StIdle);
            phase_q     <= (phase_q == PH_W'(CLK_RATIO - 1)) ? '0 : phase_q + PH_W'(1);
            if (dram_edge) begin
                gap_q  <= sat_dec(gap_q);
                data_q <= sat_dec(data_q);
                for (int i = 0; i < NUM_BANKS; i++) tras_q[i] <= sat_dec(tras_q[i]);
            end
            if (accept) begin
                is_wr_q <= (opcode_in == OP_WRITE);
                row_q   <= address_in[32:18];
                bg_q    <= address_in[7:6];
                bank_q  <= address_in[9:8];
                col_q   <= {address_in[17:10], address_in[5:3]};
            end
            if (pre_fire) begin
                open_q[bank_idx] <= 1'b0;
                gap_q            <= LD_RP;
            end
            if (act_fire) begin
                open_q[bank_idx]     <= 1'b1;
                open_row_q[bank_idx] <= row_q;
                gap_q                <= LD_RCD;
                tras_q[bank_idx]     <= LD_RAS;
            end
            if (col_fire) data_q <= is_wr_q ? LD_WR : LD_RD;
        end
    end

endmodule
